pipe_fetch_ctrl: RTL

- Pipeline control and fetch sequencer for the Y86-64 PIPE core.
- Owns the F_predPC register and selects the fetch PC each cycle: predicted PC, a mispredicted-branch recovery address, or a ret return address.
- Detects load/use, ret and mispredict hazards and drives stall/bubble controls to the F, D and E pipeline registers.
- Runs a halt/exception drain FSM that freezes the pipe once a halt or invalid instruction retires.

---
 rtl/y86_pkg.sv | 21 ++
 rtl/pipe_fetch_ctrl_if.sv | 47 ++++
 rtl/pipe_fetch_ctrl_hazard.sv | 39 +++
 rtl/pipe_fetch_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the PIPE control slice: instruction icodes,
// the "no register" id, architectural status codes and the drain FSM states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_INS = 2'b10;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

endpackage

// File: rtl/pipe_fetch_ctrl_if.sv
// Pipeline-side signal bundle of pipe_fetch_ctrl.
//   slave  : the controller (consumes stage icodes/operands, drives PC and controls)
//   master : the pipeline datapath that feeds it
interface pipe_fetch_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       f_icode;
  logic [63:0]      f_valC;
  logic [63:0]      f_valP;
  logic             f_instr_valid;
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic             e_Cnd;
  logic [3:0]       M_icode;
  logic             M_Cnd;
  logic [63:0]      M_valA;
  logic [3:0]       W_icode;
  logic [63:0]      W_valM;

  logic [63:0]      f_pc;
  logic [63:0]      F_predPC;
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic [1:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  f_icode, f_valC, f_valP, f_instr_valid, D_icode, E_icode, E_dstM,
           d_srcA, d_srcB, e_Cnd, M_icode, M_Cnd, M_valA, W_icode, W_valM,
    output f_pc, F_predPC, F_stall, D_stall, D_bubble, E_bubble, stat, halted,
           stall_cnt
  );

  modport master (
    output f_icode, f_valC, f_valP, f_instr_valid, D_icode, E_icode, E_dstM,
           d_srcA, d_srcB, e_Cnd, M_icode, M_Cnd, M_valA, W_icode, W_valM,
    input  f_pc, F_predPC, F_stall, D_stall, D_bubble, E_bubble, stat, halted,
           stall_cnt
  );

endinterface

// File: rtl/pipe_fetch_ctrl_hazard.sv
// pipe_hazard_unit: combinational hazard detection and the normal (RUN)
// stall/bubble controls.
//   in : D/E/M icodes, E_dstM, decode sources, e_Cnd
//   out: mispred, and RUN-state F_stall/D_stall/D_bubble/E_bubble
module pipe_hazard_unit
  import y86_pkg::*;
(
  input  logic [3:0] D_icode_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] E_dstM_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic       e_Cnd_i,
  input  logic [3:0] M_icode_i,
  output logic       mispred_o,
  output logic       F_stall_o,
  output logic       D_stall_o,
  output logic       D_bubble_o,
  output logic       E_bubble_o
);

  logic loaduse;
  logic ret_h;

  always_comb begin
    loaduse = ((E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ)) &&
              (E_dstM_i != RNONE) &&
              ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    ret_h     = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
    mispred_o = (E_icode_i == I_JXX) && !e_Cnd_i;

    F_stall_o  = loaduse || ret_h;
    D_stall_o  = loaduse;
    // A load/use stall keeps D as-is, so the ret bubble must not also fire.
    D_bubble_o = mispred_o || (!loaduse && ret_h);
    E_bubble_o = mispred_o || loaduse;
  end

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// pipe_fetch_ctrl: fetch PC selection, F_predPC register, pipeline control
// and halt/exception drain sequencing for the Y86-64 PIPE core.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : stage inputs (icodes, operands, conditions) and the
//                f_pc / F_predPC / stall / bubble / stat / halted / stall_cnt outputs
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_RUN    | normal operation, controls from the hazard unit
// S_DRAIN  | halt/invalid fetched; fetch frozen while it walks D->E->M->W
// S_HALTED | halting instruction retired; pipe frozen until reset
module pipe_fetch_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipe_fetch_ctrl_if.slave bus
);

  logic             run_f_stall, run_d_stall, run_d_bubble, run_e_bubble;
  logic             mispred;

  logic [1:0]       state_q, state_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       stat_q, stat_d;
  logic [63:0]      predpc_q, predpc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             f_stall, d_stall, d_bubble, e_bubble;
  logic             start_drain;

  pipe_hazard_unit u_hazard (
    .D_icode_i  (bus.D_icode),
    .E_icode_i  (bus.E_icode),
    .E_dstM_i   (bus.E_dstM),
    .d_srcA_i   (bus.d_srcA),
    .d_srcB_i   (bus.d_srcB),
    .e_Cnd_i    (bus.e_Cnd),
    .M_icode_i  (bus.M_icode),
    .mispred_o  (mispred),
    .F_stall_o  (run_f_stall),
    .D_stall_o  (run_d_stall),
    .D_bubble_o (run_d_bubble),
    .E_bubble_o (run_e_bubble)
  );

  always_comb begin
    f_stall  = run_f_stall;
    d_stall  = run_d_stall;
    d_bubble = run_d_bubble;
    e_bubble = run_e_bubble;
    case (state_q)
      S_RUN: ;
      S_DRAIN: begin
        // D is refilled with bubbles, so a D hold would be meaningless here.
        f_stall  = 1'b1;
        d_stall  = 1'b0;
        d_bubble = 1'b1;
      end
      default: begin
        f_stall  = 1'b1;
        d_stall  = 1'b0;
        d_bubble = 1'b1;
        e_bubble = 1'b1;
      end
    endcase
  end

  // Only a halt that will actually be latched into D starts the drain.
  assign start_drain = (state_q == S_RUN) &&
                       ((bus.f_icode == I_HALT) || !bus.f_instr_valid) &&
                       !run_f_stall && !run_d_bubble;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    pend_d  = pend_q;
    stat_d  = stat_q;
    case (state_q)
      S_RUN: begin
        if (start_drain) begin
          state_d = S_DRAIN;
          dcnt_d  = 2'd3;
          pend_d  = (bus.f_icode == I_HALT) ? STAT_HLT : STAT_INS;
        end
      end
      S_DRAIN: begin
        if (mispred && (dcnt_q == 2'd3)) begin
          // Halt was on the wrong path of an older jXX; forget it.
          state_d = S_RUN;
          dcnt_d  = 2'd0;
          pend_d  = STAT_AOK;
        end else if (dcnt_q == 2'd0) begin
          state_d = S_HALTED;
          stat_d  = pend_q;
        end else begin
          dcnt_d = dcnt_q - 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    predpc_d = predpc_q;
    if (!f_stall)
      predpc_d = ((bus.f_icode == I_JXX) || (bus.f_icode == I_CALL)) ? bus.f_valC : bus.f_valP;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (f_stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      dcnt_q   <= 2'd0;
      pend_q   <= STAT_AOK;
      stat_q   <= STAT_AOK;
      predpc_q <= RESET_PC;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      pend_q   <= pend_d;
      stat_q   <= stat_d;
      predpc_q <= predpc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    if ((bus.M_icode == I_JXX) && !bus.M_Cnd)
      bus.f_pc = bus.M_valA;
    else if (bus.W_icode == I_RET)
      bus.f_pc = bus.W_valM;
    else
      bus.f_pc = predpc_q;
  end

  assign bus.F_predPC  = predpc_q;
  assign bus.F_stall   = f_stall;
  assign bus.D_stall   = d_stall;
  assign bus.D_bubble  = d_bubble;
  assign bus.E_bubble  = e_bubble;
  assign bus.stat      = stat_q;
  assign bus.halted    = (state_q == S_HALTED);
  assign bus.stall_cnt = cnt_q;

endmodule
